// File: rtl/riscv_core_pkg.sv
// Core-wide types shared by the writeback path: result entry layout and sizing constants.
package riscv_core_pkg;

  localparam int unsigned NUM_PR  = 64;
  localparam int unsigned AL_SIZE = 32;
  localparam int unsigned PR_AW   = $clog2(NUM_PR);
  localparam int unsigned AL_AW   = $clog2(AL_SIZE);

  typedef struct packed {
    logic             uses_rd;
    logic [PR_AW-1:0] rd;
    logic [31:0]      data;
    logic [AL_AW-1:0] al_addr;
  } wb_entry_t;

endpackage

// File: rtl/wb_req_fifo.sv
// Two-entry result buffer for one execution-unit channel; flush empties it and drops any push.
module wb_req_fifo
  import riscv_core_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      flush,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  wb_entry_t  mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push_ok, pop_ok;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) wr_ptr_d = ~wr_ptr_q;
      if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Grants up to NUM_WB buffered results per cycle onto registered register-file write ports.
// Define WB_ARB_RR_EN for round-robin priority; otherwise lowest channel index wins.
module wb_port_arbiter
  import riscv_core_pkg::*;
#(
  parameter int unsigned NUM_REQ = 6,
  parameter int unsigned NUM_WB  = 4,
  parameter int unsigned PR_W    = $clog2(NUM_PR),
  parameter int unsigned AL_W    = $clog2(AL_SIZE)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               stall,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [PR_W-1:0]    req_rd      [NUM_REQ],
  input  logic [NUM_REQ-1:0] req_uses_rd,
  input  logic [31:0]        req_data    [NUM_REQ],
  input  logic [AL_W-1:0]    req_al_addr [NUM_REQ],
  output logic [NUM_WB-1:0]  wb_valid,
  output logic [NUM_WB-1:0]  wb_uses_rd,
  output logic [PR_W-1:0]    wb_rd       [NUM_WB],
  output logic [31:0]        wb_data     [NUM_WB],
  output logic [AL_W-1:0]    wb_al_addr  [NUM_WB],
  output logic               busy
);

  localparam int unsigned RR_W = $clog2(NUM_REQ);

  wb_entry_t           req_ent   [NUM_REQ];
  wb_entry_t           fifo_head [NUM_REQ];
  logic [NUM_REQ-1:0]  fifo_full, fifo_empty, push, pop;
  wb_entry_t           grant_ent [NUM_WB];
  logic [NUM_WB-1:0]   grant_vld;
  logic [RR_W-1:0]     start_ch;
  wb_entry_t           wb_q      [NUM_WB];
  logic [NUM_WB-1:0]   wb_valid_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
    assign req_ent[i] = '{uses_rd: req_uses_rd[i], rd: req_rd[i], data: req_data[i],
                          al_addr: req_al_addr[i]};
    assign push[i]    = req_valid[i] && req_ready[i] && !flush;

    wb_req_fifo u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .push      (push[i]),
      .push_data (req_ent[i]),
      .pop       (pop[i]),
      .head      (fifo_head[i]),
      .full      (fifo_full[i]),
      .empty     (fifo_empty[i])
    );
  end

  assign req_ready = ~fifo_full;
  assign busy      = ~&fifo_empty;

`ifdef WB_ARB_RR_EN
  logic [RR_W-1:0] rr_q, rr_d, last_ch;
  assign start_ch = rr_q;
`else
  assign start_ch = '0;
`endif

  // Cyclic scan from start_ch; the k-th non-empty channel found lands on port k.
  always_comb begin : p_arb
    int unsigned n;
    int unsigned ch;
    n         = 0;
    grant_vld = '0;
    pop       = '0;
    for (int k = 0; k < NUM_WB; k++) grant_ent[k] = '0;
`ifdef WB_ARB_RR_EN
    last_ch = rr_q;
`endif
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      ch = int'(start_ch) + off;
      if (ch >= NUM_REQ) ch = ch - NUM_REQ;
      if (!fifo_empty[ch] && n < NUM_WB) begin
        grant_vld[n] = 1'b1;
        grant_ent[n] = fifo_head[ch];
        pop[ch]      = 1'b1;
`ifdef WB_ARB_RR_EN
        last_ch      = RR_W'(ch);
`endif
        n            = n + 1;
      end
    end
    if (stall || flush) begin
      grant_vld = '0;
      pop       = '0;
    end
  end

`ifdef WB_ARB_RR_EN
  always_comb begin
    rr_d = rr_q;
    if (|grant_vld) rr_d = (last_ch == RR_W'(NUM_REQ - 1)) ? '0 : last_ch + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rr_q <= '0;
    else          rr_q <= rr_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_valid_q <= '0;
      for (int k = 0; k < NUM_WB; k++) wb_q[k] <= '0;
    end else begin
      wb_valid_q <= grant_vld;
      for (int k = 0; k < NUM_WB; k++) begin
        if (grant_vld[k]) wb_q[k] <= grant_ent[k];
      end
    end
  end

  assign wb_valid = wb_valid_q;
  for (genvar k = 0; k < NUM_WB; k++) begin : g_port
    assign wb_uses_rd[k] = wb_q[k].uses_rd;
    assign wb_rd[k]      = wb_q[k].rd;
    assign wb_data[k]    = wb_q[k].data;
    assign wb_al_addr[k] = wb_q[k].al_addr;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic vs a queue model.
module tb_wb_port_arbiter;
  import riscv_core_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n, flush, stall;
  logic [5:0] req_valid, req_ready, req_uses_rd;
  logic [5:0] req_rd      [6];
  logic [31:0] req_data   [6];
  logic [4:0] req_al_addr [6];
  logic [3:0] wb_valid, wb_uses_rd;
  logic [5:0] wb_rd       [4];
  logic [31:0] wb_data    [4];
  logic [4:0] wb_al_addr  [4];
  logic       busy;

  always #5 clk = ~clk;

  wb_port_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .stall       (stall),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_uses_rd (req_uses_rd),
    .req_data    (req_data),
    .req_al_addr (req_al_addr),
    .wb_valid    (wb_valid),
    .wb_uses_rd  (wb_uses_rd),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_al_addr  (wb_al_addr),
    .busy        (busy)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [43:0] mq [6][$];   // per-channel buffered results, {uses_rd, rd, data, al}
  int          mrr = 0;
  logic [3:0]  exp_v;
  logic [43:0] exp_f [4];
  logic [5:0]  last_hs;
  int          gcnt [6];
  logic [31:0] seen [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [5:0] rd, input logic uses,
                         input logic [31:0] data, input logic [4:0] al);
    req_valid[i]   = 1'b1;
    req_rd[i]      = rd;
    req_uses_rd[i] = uses;
    req_data[i]    = data;
    req_al_addr[i] = al;
  endtask

  // One clock: predict grants from the model's queues, advance, then compare.
  task automatic step();
    logic [5:0] rdy;
    logic [5:0] gmask;
    logic [5:0] exp_rdy;
    int n, c, last, start;
    n = 0; gmask = '0; last = -1; exp_v = '0;
`ifdef WB_ARB_RR_EN
    start = mrr;
`else
    start = 0;
`endif
    for (int i = 0; i < 6; i++) rdy[i] = (mq[i].size() < 2);
    if (reset_n && !stall && !flush) begin
      for (int off = 0; off < 6; off++) begin
        c = (start + off) % 6;
        if (mq[c].size() > 0 && n < 4) begin
          exp_v[n] = 1'b1;
          exp_f[n] = mq[c][0];
          gmask[c] = 1'b1;
          last     = c;
          n++;
        end
      end
    end
    @(posedge clk);
    #1;
    last_hs = '0;
    if (!reset_n) begin
      for (int i = 0; i < 6; i++) mq[i].delete();
      mrr = 0;
    end else if (flush) begin
      for (int i = 0; i < 6; i++) mq[i].delete();
    end else begin
      for (int i = 0; i < 6; i++) if (gmask[i]) mq[i].delete(0);
      for (int i = 0; i < 6; i++) begin
        if (req_valid[i] && rdy[i]) begin
          mq[i].push_back({req_uses_rd[i], req_rd[i], req_data[i], req_al_addr[i]});
          last_hs[i] = 1'b1;
        end
      end
`ifdef WB_ARB_RR_EN
      if (last >= 0) mrr = (last + 1) % 6;
`endif
    end
    chk("wb_valid", 64'(wb_valid), 64'(exp_v));
    for (int k = 0; k < 4; k++) begin
      if (exp_v[k]) chk($sformatf("wb_entry%0d", k),
                        64'({wb_uses_rd[k], wb_rd[k], wb_data[k], wb_al_addr[k]}), 64'(exp_f[k]));
      if (wb_valid[k]) begin
        seen.push_back(wb_data[k]);
        if (wb_data[k][31:28] < 4'd6) gcnt[wb_data[k][31:28]]++;
      end
    end
    for (int i = 0; i < 6; i++) exp_rdy[i] = (mq[i].size() < 2);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("busy", 64'(busy), 64'(exp_rdy != 6'h3f || mq[0].size() + mq[1].size() + mq[2].size()
                                + mq[3].size() + mq[4].size() + mq[5].size() > 0));
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0; req_valid = '0; stall = 1'b0; flush = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    chk({tag, "_ready"}, 64'(req_ready), 64'h3f);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    for (int k = 0; k < 4; k++)
      chk({tag, "_fields"}, 64'({wb_uses_rd[k], wb_rd[k], wb_data[k], wb_al_addr[k]}), 64'd0);
  endtask

  initial begin
    bit accepted;
    reset_n = 1'b0; flush = 1'b0; stall = 1'b0; req_valid = '0; req_uses_rd = '0;
    for (int i = 0; i < 6; i++) begin
      req_rd[i] = '0; req_data[i] = '0; req_al_addr[i] = '0;
    end
    for (int i = 0; i < 6; i++) gcnt[i] = 0;
    step();
    step();
    check_reset_state("reset");
    reset_n = 1'b1;

    // Single result on channel 2
    set_req(2, 6'd17, 1'b1, 32'hDEADBEEF, 5'd5);
    step();
    req_valid = '0;
    chk("single_early", 64'(wb_valid), 64'd0);
    step();
    chk("single_valid", 64'(wb_valid), 64'b0001);
    chk("single_rd", 64'(wb_rd[0]), 64'd17);
    chk("single_data", 64'(wb_data[0]), 64'hDEADBEEF);
    chk("single_al", 64'(wb_al_addr[0]), 64'd5);
    step();
    chk("single_oneshot", 64'(wb_valid), 64'd0);

    // All six channels at once from rr_ptr = 0
    pulse_reset();
    for (int i = 0; i < 6; i++) set_req(i, 6'(i + 1), 1'b1, {4'(i), 28'h0ABCDE0}, 5'(i));
    step();
    req_valid = '0;
    step();
    chk("burst1_valid", 64'(wb_valid), 64'hf);
    for (int k = 0; k < 4; k++) chk("burst1_chan", 64'(wb_data[k][31:28]), 64'(k));
    step();
    chk("burst2_valid", 64'(wb_valid), 64'b0011);
    chk("burst2_chan0", 64'(wb_data[0][31:28]), 64'd4);
    chk("burst2_chan1", 64'(wb_data[1][31:28]), 64'd5);
    step();

    // Backpressure on channel 1 while stalled
    seen.delete();
    stall = 1'b1;
    for (int j = 0; j < 2; j++) begin
      set_req(1, 6'd9, 1'b1, 32'h1000_0000 + j, 5'd3);
      step();
    end
    chk("bp_ready_low", 64'(req_ready[1]), 64'd0);
    set_req(1, 6'd9, 1'b0, 32'h1000_0002, 5'd3);
    step();
    chk("bp_held", 64'(last_hs[1]), 64'd0);
    stall = 1'b0;
    accepted = 1'b0;
    for (int t = 0; t < 8 && !accepted; t++) begin
      step();
      if (last_hs[1]) accepted = 1'b1;
    end
    chk("bp_accept", 64'(accepted), 64'd1);
    req_valid = '0;
    repeat (3) step();
    chk("bp_count", 64'(seen.size()), 64'd3);
    for (int j = 0; j < 3 && j < seen.size(); j++)
      chk("bp_order", 64'(seen[j]), 64'(32'h1000_0000 + j));

    // Flush with eight results buffered and a concurrent push
    stall = 1'b1;
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 4; i++) set_req(i, 6'd2, 1'b1, 32'h2000_0000 + 32'(j * 4 + i), 5'd1);
      step();
    end
    chk("fl_busy_before", 64'(busy), 64'd1);
    seen.delete();
    req_valid = '0;
    set_req(4, 6'd3, 1'b1, 32'h2000_00FF, 5'd2);
    flush = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0; req_valid = '0;
    chk("fl_busy", 64'(busy), 64'd0);
    chk("fl_ready", 64'(req_ready), 64'h3f);
    repeat (4) step();
    chk("fl_no_wb", 64'(seen.size()), 64'd0);

    // Sustained load on all channels
    pulse_reset();
    for (int i = 0; i < 6; i++) set_req(i, 6'(i), 1'b1, {4'(i), 28'h0000123}, 5'(i));
    step();
    for (int i = 0; i < 6; i++) gcnt[i] = 0;
    repeat (30) step();
    for (int i = 0; i < 6; i++) begin
`ifdef WB_ARB_RR_EN
      chk($sformatf("fair_ch%0d", i), 64'(gcnt[i]), 64'd20);
`else
      chk($sformatf("fixed_ch%0d", i), 64'(gcnt[i]), (i < 4) ? 64'd30 : 64'd0);
`endif
    end
    req_valid = '0;
    repeat (4) step();

    // Mid-run reset with results buffered and non-zero output fields
    for (int i = 0; i < 3; i++) set_req(i, 6'h3f, 1'b1, 32'h3000_0000 + i, 5'h1f);
    step();
    req_valid = '0;
    stall = 1'b1;
    for (int i = 3; i < 6; i++) set_req(i, 6'h2a, 1'b1, 32'h3000_0010 + i, 5'h0a);
    step();
    req_valid = '0;
    reset_n = 1'b0;
    step();
    check_reset_state("midreset");
    reset_n = 1'b1; stall = 1'b0;
    seen.delete();
    repeat (4) step();
    chk("midreset_no_stale", 64'(seen.size()), 64'd0);

    // Random traffic against the model
    for (int t = 0; t < 400; t++) begin
      req_valid = 6'($urandom);
      for (int i = 0; i < 6; i++) begin
        req_rd[i] = 6'($urandom); req_uses_rd[i] = 1'($urandom);
        req_data[i] = $urandom; req_al_addr[i] = 5'($urandom);
      end
      stall = ($urandom_range(9) == 0);
      flush = ($urandom_range(29) == 0);
      step();
    end
    req_valid = '0; stall = 1'b0; flush = 1'b0;
    repeat (4) step();
    chk("drained_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
